toy_bus_dmrg2ch_node_mrg_dmem: RTL

//  2:1 merge node; the upstream counterpart of the 2-ch address-decode node.

---
 rtl/toy_bus_pkg.sv | 31 +++
 rtl/toy_bus_dmrg2ch_node_mrg_dmem_if.sv | 21 ++
 rtl/toy_bus_ord_fifo.sv | 66 ++++++
 rtl/toy_bus_dmrg2ch_node_mrg_dmem.sv | 138 +++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// Shared ToyBus field widths, opcodes and request/ack payload types.
package toy_bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned STRB_W = 32;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned SB_W   = 10;

   localparam logic OPC_RD = 1'b0;
   localparam logic OPC_WR = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] data;
      logic              opcode;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
      logic [SB_W-1:0]   sideband;
   } ToyBusReq;

   typedef struct packed {
      logic              opcode;
      logic [DATA_W-1:0] data;
      logic [SB_W-1:0]   sideband;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } ToyBusAck;

endpackage

// File: rtl/toy_bus_dmrg2ch_node_mrg_dmem_if.sv
// One ToyBus port: request channel out of the initiator, ack channel back.
interface toy_bus_dmrg2ch_node_mrg_dmem_if;
   import toy_bus_pkg::*;

   logic     req_vld;
   logic     req_rdy;
   ToyBusReq req;
   logic     ack_vld;
   logic     ack_rdy;
   ToyBusAck ack;

   modport master (
      output req_vld, req, ack_rdy,
      input  req_rdy, ack_vld, ack
   );

   modport slave (
      input  req_vld, req, ack_rdy,
      output req_rdy, ack_vld, ack
   );
endinterface

// File: rtl/toy_bus_ord_fifo.sv
// Order FIFO: remembers which initiator owns each outstanding request.
module toy_bus_ord_fifo #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        push_idx,
   input  logic        pop,
   output logic        head_idx,
   output logic        full,
   output logic        empty,
   output logic [AW:0] cnt
);

   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;

   // Pointer/occupancy update; simultaneous push and pop leave cnt unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_idx;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_idx = mem_q[rd_ptr_q];
   assign full     = (cnt_q == CNT_FULL);
   assign empty    = (cnt_q == '0);
   assign cnt      = cnt_q;

endmodule

// File: rtl/toy_bus_dmrg2ch_node_mrg_dmem.sv
// 2:1 ToyBus merge node: round-robin request arbitration onto out0, with
// in-order ack routing back to the issuing initiator via an order FIFO.
// Build option: TOY_BUS_MRG_REQ_SLICE_EN adds a 1-entry register slice on out0 req.
module toy_bus_dmrg2ch_node_mrg_dmem
   import toy_bus_pkg::*;
#(
   parameter  int unsigned OSTD_DEPTH = 4,
   localparam int unsigned OSTD_AW    = $clog2(OSTD_DEPTH)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   toy_bus_dmrg2ch_node_mrg_dmem_if.slave       in0,
   toy_bus_dmrg2ch_node_mrg_dmem_if.slave       in1,
   toy_bus_dmrg2ch_node_mrg_dmem_if.master      out0,
   output logic [OSTD_AW:0]                     ostd_cnt
);

   typedef enum logic [1:0] {
      ARB_OPEN  = 2'd0,
      ARB_HOLD0 = 2'd1,
      ARB_HOLD1 = 2'd2
   } arb_state_e;

   arb_state_e arb_state_q, arb_state_d;
   logic       rr_last_q, rr_last_d;

   logic       grant;
   logic       arb_vld, arb_rdy, arb_hs;
   ToyBusReq   arb_req;
   logic       fifo_full, fifo_empty, fifo_head;
   logic       head_ack_rdy, pop, block;

   // Ack routing to the FIFO head initiator; pop on the ack handshake.
   always_comb begin
      head_ack_rdy = fifo_head ? in1.ack_rdy : in0.ack_rdy;
      out0.ack_rdy = !rst && !fifo_empty && head_ack_rdy;
      pop          = out0.ack_vld && out0.ack_rdy;
      in0.ack_vld  = !rst && out0.ack_vld && !fifo_empty && !fifo_head;
      in1.ack_vld  = !rst && out0.ack_vld && !fifo_empty &&  fifo_head;
      in0.ack      = out0.ack;
      in1.ack      = out0.ack;
   end

   // Arbitration: locked grant wins, else round-robin, else the lone requester.
   always_comb begin
      case (arb_state_q)
         ARB_HOLD0: grant = 1'b0;
         ARB_HOLD1: grant = 1'b1;
         default: begin
            if (in0.req_vld && in1.req_vld) grant = ~rr_last_q;
            else                            grant = in1.req_vld;
         end
      endcase
      // A full FIFO still takes a request when an ack frees a slot this cycle.
      block   = fifo_full && !pop;
      arb_vld = !rst && (in0.req_vld || in1.req_vld) && !block;
      arb_req = grant ? in1.req : in0.req;
      arb_hs  = arb_vld && arb_rdy;
      in0.req_rdy = !rst && arb_rdy && !block && !grant;
      in1.req_rdy = !rst && arb_rdy && !block &&  grant;
   end

   // Grant lock and round-robin pointer next state.
   always_comb begin
      arb_state_d = ARB_OPEN;
      rr_last_d   = rr_last_q;
      if (arb_vld && !arb_rdy) begin
         arb_state_d = grant ? ARB_HOLD1 : ARB_HOLD0;
      end
      if (arb_hs) begin
         rr_last_d = grant;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         arb_state_q <= ARB_OPEN;
         rr_last_q   <= 1'b1;
      end else begin
         arb_state_q <= arb_state_d;
         rr_last_q   <= rr_last_d;
      end
   end

`ifdef TOY_BUS_MRG_REQ_SLICE_EN
   logic     slice_vld_q, slice_vld_d;
   ToyBusReq slice_req_q, slice_req_d;

   // Slice accepts whenever empty or draining, so back-to-back beats flow.
   always_comb begin
      arb_rdy     = !slice_vld_q || out0.req_rdy;
      slice_vld_d = slice_vld_q;
      slice_req_d = slice_req_q;
      if (arb_hs) begin
         slice_vld_d = 1'b1;
         slice_req_d = arb_req;
      end else if (out0.req_rdy) begin
         slice_vld_d = 1'b0;
      end
      out0.req_vld = !rst && slice_vld_q;
      out0.req     = slice_req_q;
   end

   // Slice registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         slice_vld_q <= 1'b0;
         slice_req_q <= '0;
      end else begin
         slice_vld_q <= slice_vld_d;
         slice_req_q <= slice_req_d;
      end
   end
`else
   // Combinational request path.
   always_comb begin
      arb_rdy      = out0.req_rdy;
      out0.req_vld = arb_vld;
      out0.req     = arb_req;
   end
`endif

   toy_bus_ord_fifo #(
      .DEPTH (OSTD_DEPTH)
   ) u_ord_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (arb_hs),
      .push_idx (grant),
      .pop      (pop),
      .head_idx (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .cnt      (ostd_cnt)
   );

endmodule
